// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - motion-estimator helpers shared by the SAD array and search-window control
package me_pkg;

   localparam int unsigned FN_W = 32;

   function automatic logic [FN_W-1:0] abs_diff(input logic [FN_W-1:0] a,
                                                input logic [FN_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   // Clamps to the all-ones value of a w-bit accumulator; w must not exceed FN_W-1.
   function automatic logic [FN_W-1:0] sat_add(input logic [FN_W-1:0] acc,
                                               input logic [FN_W-1:0] d,
                                               input int unsigned     w);
      logic [FN_W:0] sum;
      logic [FN_W:0] max;
      sum = {1'b0, acc} + {1'b0, d};
      max = ({{FN_W{1'b0}}, 1'b1} << w) - 1'b1;
      return (sum > max) ? max[FN_W-1:0] : sum[FN_W-1:0];
   endfunction

   function automatic int unsigned idx_w(input int unsigned n);
      if (n < 2) return 1;
      return $unsigned($clog2(n));
   endfunction

endpackage

// File: rtl/pe_sad_cell.sv
// rtl/pe_sad_cell.sv - one SAD processing element: stream mux, abs-diff, saturating
// accumulator, primed flag and the stage-1 completion latch
module pe_sad_cell
   import me_pkg::*;
#(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned ACC_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid_i,
   input  logic [PIX_W-1:0] r_i,
   input  logic [PIX_W-1:0] s1_i,
   input  logic [PIX_W-1:0] s2_i,
   input  logic             sel_i,
   input  logic             new_dist_i,
   output logic [ACC_W-1:0] acc_o,
   output logic             done_o,
   output logic [ACC_W-1:0] done_val_o
);

   logic [PIX_W-1:0] s_pix;
   logic [ACC_W-1:0] diff;
   logic [ACC_W-1:0] acc_sum;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] done_val_q, done_val_d;
   logic             primed_q, primed_d;
   logic             done_q, done_d;

   assign s_pix   = sel_i ? s2_i : s1_i;
   assign diff    = ACC_W'(abs_diff(FN_W'(r_i), FN_W'(s_pix)));
   assign acc_sum = ACC_W'(sat_add(FN_W'(acc_q), FN_W'(diff), ACC_W));

   // done pulses for exactly one cycle; the value latch only moves on a restart.
   always_comb begin
      acc_d      = acc_q;
      primed_d   = primed_q;
      done_d     = 1'b0;
      done_val_d = done_val_q;
      if (in_valid_i) begin
         if (new_dist_i) begin
            acc_d      = diff;
            done_d     = primed_q;
            done_val_d = acc_q;
            primed_d   = 1'b1;
         end else begin
            acc_d = acc_sum;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q      <= '0;
         primed_q   <= 1'b0;
         done_q     <= 1'b0;
         done_val_q <= '0;
      end else begin
         acc_q      <= acc_d;
         primed_q   <= primed_d;
         done_q     <= done_d;
         done_val_q <= done_val_d;
      end
   end

   assign acc_o      = acc_q;
   assign done_o     = done_q;
   assign done_val_o = done_val_q;

endmodule

// File: rtl/pe_array_sad.sv
// rtl/pe_array_sad.sv - N_PE SAD elements with a min-reduction tree and registered
// best-match tracker
module pe_array_sad
   import me_pkg::*;
#(
   parameter int unsigned N_PE  = 16,
   parameter int unsigned PIX_W = 8,
   parameter int unsigned ACC_W = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [PIX_W-1:0]        R,
   input  logic [PIX_W-1:0]        S1,
   input  logic [PIX_W-1:0]        S2,
   input  logic [N_PE-1:0]         s_sel,
   input  logic [N_PE-1:0]         new_dist,
   input  logic                    frame_start,
   output logic [N_PE*ACC_W-1:0]   acc_out,
   output logic [ACC_W-1:0]        best_dist,
   output logic [idx_w(N_PE)-1:0]  best_idx,
   output logic                    best_valid
);

   localparam int unsigned IDX_W  = idx_w(N_PE);
   localparam int unsigned LEAVES = 1 << IDX_W;
   localparam int unsigned NODES  = 2 * LEAVES - 1;

   logic [ACC_W-1:0] acc_w      [N_PE];
   logic             done_w     [N_PE];
   logic [ACC_W-1:0] done_val_w [N_PE];

   for (genvar k = 0; k < N_PE; k++) begin : g_pe
      pe_sad_cell #(
         .PIX_W (PIX_W),
         .ACC_W (ACC_W)
      ) u_cell (
         .clock      (clock),
         .reset      (reset),
         .in_valid_i (in_valid),
         .r_i        (R),
         .s1_i       (S1),
         .s2_i       (S2),
         .sel_i      (s_sel[k]),
         .new_dist_i (new_dist[k]),
         .acc_o      (acc_w[k]),
         .done_o     (done_w[k]),
         .done_val_o (done_val_w[k])
      );
      assign acc_out[k*ACC_W +: ACC_W] = acc_w[k];
   end

   // Heap-ordered tree: node n has children 2n+1 (lower indices) and 2n+2, so the
   // left child wins ties and the root carries the lowest-index minimum.
   logic             node_vld [NODES];
   logic [ACC_W-1:0] node_val [NODES];
   logic [IDX_W-1:0] node_idx [NODES];

   always_comb begin
      for (int n = 0; n < NODES; n++) begin
         node_vld[n] = 1'b0;
         node_val[n] = '1;
         node_idx[n] = '0;
      end
      for (int k = 0; k < N_PE; k++) begin
         node_vld[LEAVES-1+k] = done_w[k];
         node_val[LEAVES-1+k] = done_val_w[k];
         node_idx[LEAVES-1+k] = IDX_W'(k);
      end
      for (int n = LEAVES - 2; n >= 0; n--) begin
         if (node_vld[2*n+2] &&
             (!node_vld[2*n+1] || (node_val[2*n+2] < node_val[2*n+1]))) begin
            node_vld[n] = 1'b1;
            node_val[n] = node_val[2*n+2];
            node_idx[n] = node_idx[2*n+2];
         end else begin
            node_vld[n] = node_vld[2*n+1];
            node_val[n] = node_val[2*n+1];
            node_idx[n] = node_idx[2*n+1];
         end
      end
   end

   logic [ACC_W-1:0] best_dist_q, best_dist_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic             best_valid_q, best_valid_d;

   always_comb begin
      best_dist_d  = best_dist_q;
      best_idx_d   = best_idx_q;
      best_valid_d = best_valid_q;
      if (frame_start) begin
         best_dist_d  = '1;
         best_idx_d   = '0;
         best_valid_d = 1'b0;
      end else if (node_vld[0] && (!best_valid_q || (node_val[0] < best_dist_q))) begin
         best_dist_d  = node_val[0];
         best_idx_d   = node_idx[0];
         best_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         best_dist_q  <= '1;
         best_idx_q   <= '0;
         best_valid_q <= 1'b0;
      end else begin
         best_dist_q  <= best_dist_d;
         best_idx_q   <= best_idx_d;
         best_valid_q <= best_valid_d;
      end
   end

   assign best_dist  = best_dist_q;
   assign best_idx   = best_idx_q;
   assign best_valid = best_valid_q;

endmodule

// File: tb/tb_pe_array_sad.sv
// tb/tb_pe_array_sad.sv - directed self-checking bench for pe_array_sad
module tb_pe_array_sad;

   localparam int N_PE  = 16;
   localparam int PIX_W = 8;
   localparam int ACC_W = 16;

   logic                  clock = 1'b0;
   logic                  reset;
   logic                  in_valid;
   logic [PIX_W-1:0]      R, S1, S2;
   logic [N_PE-1:0]       s_sel, new_dist;
   logic                  frame_start;
   logic [N_PE*ACC_W-1:0] acc_out;
   logic [ACC_W-1:0]      best_dist;
   logic [3:0]            best_idx;
   logic                  best_valid;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   pe_array_sad #(
      .N_PE  (N_PE),
      .PIX_W (PIX_W),
      .ACC_W (ACC_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .R           (R),
      .S1          (S1),
      .S2          (S2),
      .s_sel       (s_sel),
      .new_dist    (new_dist),
      .frame_start (frame_start),
      .acc_out     (acc_out),
      .best_dist   (best_dist),
      .best_idx    (best_idx),
      .best_valid  (best_valid)
   );

   typedef struct {
      logic        in_valid;
      logic [15:0] s_sel;
      logic [15:0] new_dist;
      logic [15:0] exp_acc0;
      logic [15:0] exp_acc1;
      logic [15:0] exp_best;
      logic [3:0]  exp_idx;
      logic        exp_bv;
   } vec_t;

   vec_t tbl [10];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic check_best(input string name, input logic [15:0] d,
                             input logic [3:0] i, input logic v);
      check({name, ".best_dist"},  32'(best_dist),  32'(d));
      check({name, ".best_idx"},   32'(best_idx),   32'(i));
      check({name, ".best_valid"}, 32'(best_valid), 32'(v));
   endtask

   function automatic logic [15:0] acc_of(input int k);
      return acc_out[k*ACC_W +: ACC_W];
   endfunction

   initial begin
      logic [15:0] pat;
      pat = 16'hF531;

      // Valid/invalid interleave starting from PE0=5, PE1=1 (d0=5, d1=1).
      tbl[0] = '{1'b1, 16'hF531, 16'h0000, 16'd10, 16'd2, 16'd16, 4'd1, 1'b1};
      tbl[1] = '{1'b0, 16'hF531, 16'h0000, 16'd10, 16'd2, 16'd16, 4'd1, 1'b1};
      tbl[2] = '{1'b1, 16'hF531, 16'h0000, 16'd15, 16'd3, 16'd16, 4'd1, 1'b1};
      tbl[3] = '{1'b0, 16'hF531, 16'hFFFF, 16'd15, 16'd3, 16'd16, 4'd1, 1'b1};
      tbl[4] = '{1'b1, 16'hF531, 16'h0000, 16'd20, 16'd4, 16'd16, 4'd1, 1'b1};
      tbl[5] = '{1'b0, 16'hF531, 16'h0000, 16'd20, 16'd4, 16'd16, 4'd1, 1'b1};
      tbl[6] = '{1'b1, 16'hF531, 16'h0000, 16'd25, 16'd5, 16'd16, 4'd1, 1'b1};
      tbl[7] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'd25, 16'd5, 16'd16, 4'd1, 1'b1};
      tbl[8] = '{1'b1, 16'hF531, 16'h0000, 16'd30, 16'd6, 16'd16, 4'd1, 1'b1};
      tbl[9] = '{1'b0, 16'hF531, 16'h0000, 16'd30, 16'd6, 16'd16, 4'd1, 1'b1};

      reset = 1'b1; in_valid = 1'b0; frame_start = 1'b0;
      R = '0; S1 = '0; S2 = '0; s_sel = '0; new_dist = '0;
      tick(); tick();
      check("reset.acc_any", 32'(|acc_out), 32'd0);
      check_best("reset", 16'hFFFF, 4'd0, 1'b0);
      reset = 1'b0;

      // 16 samples: set-bit PEs see |3-8|=5, others |3-2|=1.
      R = 8'd3; S1 = 8'd2; S2 = 8'd8; s_sel = pat;
      in_valid = 1'b1; new_dist = 16'hFFFF;
      tick();
      new_dist = 16'h0000;
      for (int c = 0; c < 15; c++) tick();
      for (int k = 0; k < N_PE; k++)
         check($sformatf("sum16.acc%0d", k), 32'(acc_of(k)), pat[k] ? 32'd80 : 32'd16);
      check("sum16.best_valid", 32'(best_valid), 32'd0);

      new_dist = 16'hFFFF;
      tick();
      check("restart.acc0", 32'(acc_of(0)), 32'd5);
      check("restart.acc1", 32'(acc_of(1)), 32'd1);
      check("restart.best_valid", 32'(best_valid), 32'd0);

      for (int i = 0; i < 10; i++) begin
         in_valid = tbl[i].in_valid;
         s_sel    = tbl[i].s_sel;
         new_dist = tbl[i].new_dist;
         tick();
         check($sformatf("tbl%0d.acc0", i), 32'(acc_of(0)), 32'(tbl[i].exp_acc0));
         check($sformatf("tbl%0d.acc1", i), 32'(acc_of(1)), 32'(tbl[i].exp_acc1));
         check_best($sformatf("tbl%0d", i), tbl[i].exp_best, tbl[i].exp_idx, tbl[i].exp_bv);
      end

      // PE1 alone completes 10, then frame_start on the next edge discards it.
      s_sel = pat; in_valid = 1'b1; new_dist = 16'h0000;
      for (int c = 0; c < 4; c++) tick();
      check("pre10.acc1", 32'(acc_of(1)), 32'd10);
      new_dist = 16'h0002;
      tick();
      check("done10.acc1", 32'(acc_of(1)), 32'd1);
      check_best("done10", 16'd16, 4'd1, 1'b1);
      new_dist = 16'h0000; frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check_best("frame", 16'hFFFF, 4'd0, 1'b0);
      for (int c = 0; c < 38; c++) tick();
      check("pre40.acc1", 32'(acc_of(1)), 32'd40);
      new_dist = 16'h0002;
      tick();
      check_best("done40.stage1", 16'hFFFF, 4'd0, 1'b0);
      in_valid = 1'b0; new_dist = 16'h0000;
      tick();
      check_best("done40", 16'd40, 4'd1, 1'b1);
      check("done40.acc1_hold", 32'(acc_of(1)), 32'd1);

      // d=255 everywhere; 257 samples land exactly on 65535, later ones clamp.
      R = 8'd255; S1 = 8'd0; S2 = 8'd0; s_sel = '0;
      in_valid = 1'b1; new_dist = 16'hFFFF;
      tick();
      new_dist = 16'h0000;
      for (int n = 2; n <= 301; n++) begin
         tick();
         if (n == 2)   check_best("sat.prev_done", 16'd1, 4'd1, 1'b1);
         if (n == 256) check("sat.acc0_256", 32'(acc_of(0)), 32'd65280);
         if (n == 257) check("sat.acc0_257", 32'(acc_of(0)), 32'd65535);
         if (n == 258) check("sat.acc15_258", 32'(acc_of(15)), 32'd65535);
      end
      check("sat.acc0_end", 32'(acc_of(0)), 32'd65535);
      check("sat.acc15_end", 32'(acc_of(15)), 32'd65535);

      // Reset overrides a concurrent restart; the next restart reports nothing.
      new_dist = 16'hFFFF; reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst2.acc_any", 32'(|acc_out), 32'd0);
      check_best("rst2", 16'hFFFF, 4'd0, 1'b0);
      R = 8'd3; S1 = 8'd2; S2 = 8'd8; s_sel = pat; new_dist = 16'hFFFF;
      tick();
      check("rst2.acc0", 32'(acc_of(0)), 32'd5);
      check("rst2.acc1", 32'(acc_of(1)), 32'd1);
      in_valid = 1'b0; new_dist = 16'h0000;
      tick();
      check_best("rst2.after", 16'hFFFF, 4'd0, 1'b0);
      tick();
      check("rst2.after2.best_valid", 32'(best_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pe_array_sad.md
# pe_array_sad

Parametrised processing-element array for the motion estimator's block-matching datapath. Each of N_PE elements accumulates the sum of absolute differences (SAD) between a reference pixel and a per-element choice of two search-window pixel streams. A registered best-match tracker reports the minimum completed distortion and the index of the element that produced it. It replaces the fixed 16-PE, 8-bit-accumulator array and adds reset, valid gating, saturation and minimum search.

## Interface
Parameters:
- N_PE, 16, number of processing elements (≥2)
- PIX_W, 8, pixel width
- ACC_W, 16, accumulator width per element (≥ PIX_W)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  pixel triple valid this cycle
- R  in  PIX_W  reference pixel (broadcast)
- S1  in  PIX_W  search pixel stream 1
- S2  in  PIX_W  search pixel stream 2
- s_sel  in  N_PE  bit k: PE k uses S2 (1) or S1 (0)
- new_dist  in  N_PE  bit k: PE k starts a new distortion
- frame_start  in  1  clear best-match tracker
- acc_out  out  N_PE*ACC_W  PE k accumulator at bits [k*ACC_W +: ACC_W]
- best_dist  out  ACC_W  minimum completed distortion
- best_idx  out  $clog2(N_PE)  PE index of best_dist
- best_valid  out  1  best_dist/best_idx hold a real result

## Operation
- d_k = |R − (s_sel[k] ? S2 : S1)|, computed unsigned at PIX_W+1 bits.
- On an edge with in_valid=1:
  - new_dist[k]=1: acc_k ← d_k. If primed_k=1, the old acc_k is a completed distortion and is latched into the stage-1 register with done_k=1. primed_k ← 1.
  - new_dist[k]=0: acc_k ← min(acc_k + d_k, 2^ACC_W−1). Saturation is sticky until the next restart.
- in_valid=0: accumulators and primed flags hold, no completions, and s_sel/new_dist are ignored.
- Stage 2, the edge after stage 1: across all done_k, pick the minimum value, lowest index winning ties. The candidate replaces the best only if it is strictly less than best_dist or best_valid=0. On replacement, best_valid ← 1.
- frame_start=1: best_dist ← all ones, best_idx ← 0, best_valid ← 0. Any stage-1 result compared at the same edge is discarded. Stage-1 capture from the same edge proceeds normally. Accumulators are unaffected.
- reset=1 (wins over everything): all acc_k, primed_k and done_k are 0, best_dist is all ones, best_idx is 0, best_valid is 0. A reset during accumulation discards partial sums, and the first restart afterwards does not report a completion.

## Timing
- acc_out is registered: it reflects a sampled input 1 edge after that edge.
- Completion-to-best latency: restart at edge E makes best_* update at edge E+1.
- Fully pipelined: one input triple per clock. Back-to-back restarts each report completions, and the compare stage accepts a new set every cycle.
- Reset values: acc_out=0, best_dist=2^ACC_W−1, best_idx=0, best_valid=0.
- Simultaneous completion in multiple PEs: a single comparison decides it, and the lowest index wins ties.

## Structure
- Shared package `me_pkg`: the abs-diff and saturating-add functions and the index width function ($clog2 wrapper). It is shared with the future search-window controller.
- Sub-module `pe_sad_cell`: one PE holding the mux, abs-diff, saturating accumulator, primed flag and completion latch, instantiated N_PE times with a generate loop.
- The min-reduction tree and best registers live in the top level.

## Test plan
- Reset, then R=3, S1=2, S2=8, s_sel=16'hF531. Cycle 0 has new_dist=16'hFFFF, then 15 cycles with new_dist=0, in_valid=1 throughout. Required result: PEs whose s_sel bit is set read 80, the others read 16, and best_valid stays 0 because no PE was primed.
- Continue with one cycle of new_dist=16'hFFFF, in_valid=1. Required result 1 edge later: best_dist=16, best_idx=1, best_valid=1. The accumulators restart at 5 and 1.
- in_valid toggled 1/0 over 10 cycles with the same pixels: acc_out holds during 0 cycles and advances only on valid cycles. Asserting new_dist during an invalid cycle has no effect.
- R=255, S1=0, s_sel=0, restart then 300 valid cycles: acc reaches 65535 at the 257th accumulation and remains 65535.
- A completion with value 10 at edge E and frame_start=1 at edge E+1: best_valid=0 and best_dist=16'hFFFF afterwards. A following completion of 40 sets best_dist=40.
- reset for 1 cycle mid-accumulation, then restart: acc_out=0 after reset, and no best_* update on the first restart.
